// File: rtl/oso_pkg.sv
// Shared definitions for the onstate/ontransit driver: state encoding and
// default parameter values used by the top module and the timeout timer.
package oso_pkg;

  localparam int OSO_HOLD_W = 8;
  localparam int OSO_TMO    = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    HOLD = 3'd2,
    REL  = 3'd3,
    DONE = 3'd4
  } oso_state_t;

endpackage

// File: rtl/oso_timer.sv
// Saturating handshake timeout counter. 'expired' is high during the TMO-th
// consecutive enabled cycle, so the owner can leave on that very edge.
module oso_timer import oso_pkg::*; #(
  parameter int TMO = OSO_TMO
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] count;

  // Count enabled cycles; clear wins over enable and the count never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CW'(TMO))) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count >= CW'(TMO - 1));

endmodule

// File: rtl/onstate_ontransit_driver.sv
// Request driver for the onstate/ontransit FSM. Raises the request line,
// waits for the transit acknowledge f, holds the request for a programmed
// number of cycles, releases it and waits for the on-state indication g to
// drop. Both handshake waits are guarded by a timeout that sets a sticky err.
// The request line is named do_req because 'do' is a reserved word.
// All outputs are registered from the next state, so they line up with the
// state register: do_req is high exactly while in REQ or HOLD.
module onstate_ontransit_driver import oso_pkg::*; #(
  parameter int HOLD_W = OSO_HOLD_W,
  parameter int TMO    = OSO_TMO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_len,
  output logic              do_req,
  input  logic              f,
  input  logic              g,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        txn_cnt
);

  oso_state_t        state;
  oso_state_t        next_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              tmr_clear;
  logic              tmr_enable;
  logic              tmr_expired;
  logic              timeout_hit;

  oso_timer #(
    .TMO(TMO)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  // Next-state logic; a handshake arriving on the timeout cycle wins.
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = REQ;
      end
      REQ: begin
        if (f) begin
          next_state = HOLD;
        end else if (tmr_expired) begin
          next_state  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_W'(1)) next_state = REL;
      end
      REL: begin
        if (!g) begin
          next_state = DONE;
        end else if (tmr_expired) begin
          next_state  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    tmr_clear  = (next_state != state);
    tmr_enable = (state == REQ) || (state == REL);
  end

  // State register plus registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      do_req  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      txn_cnt <= 8'd0;
    end else begin
      state  <= next_state;
      do_req <= (next_state == REQ) || (next_state == HOLD);
      busy   <= (next_state != IDLE);
      done   <= (next_state == DONE);
      if (timeout_hit) err <= 1'b1;
      if (next_state == DONE) txn_cnt <= txn_cnt + 8'd1;
    end
  end

  // Hold length is captured with start (zero means one) and counted down in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      hold_cnt <= (hold_len == '0) ? HOLD_W'(1) : hold_len;
    end else if (state == HOLD) begin
      hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

endmodule

// File: tb/tb_onstate_ontransit_driver.sv
// Scoreboard bench for onstate_ontransit_driver. Each transaction pushes its
// hand-computed outcome; a monitor pops it when busy falls and compares.
module tb_onstate_ontransit_driver;

  typedef struct {
    int do_c;
    int done_c;
    int err_v;
    int txn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] hold_len = 8'd0;
  logic       do_req;
  logic       f = 1'b0;
  logic       g = 1'b0;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] txn_cnt;

  int vectors = 0;
  int miscompares = 0;

  exp_t sb_q[$];
  exp_t e;
  int   mon_do = 0;
  int   mon_done = 0;
  int   total_done = 0;
  logic prev_busy = 1'b0;

  int f_lat = 1000;
  int g_lat = 0;
  int g_stuck = 0;
  int hi_cnt = 0;
  int lo_cnt = 0;

  onstate_ontransit_driver #(
    .HOLD_W(8),
    .TMO   (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .hold_len(hold_len),
    .do_req  (do_req),
    .f       (f),
    .g       (g),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .txn_cnt (txn_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model of the controlled FSM answering the request line.
  always @(negedge clk) begin
    if (do_req) begin
      hi_cnt = hi_cnt + 1;
      lo_cnt = 0;
    end else begin
      hi_cnt = 0;
      if (lo_cnt < 1000) lo_cnt = lo_cnt + 1;
    end
    f = do_req && (hi_cnt >= f_lat);
    g = (g_stuck != 0) || (lo_cnt < g_lat);
  end

  task automatic checkOutput(input string name, input int act, input int expv);
    vectors = vectors + 1;
    if (act != expv) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: accumulate per-transaction activity and score it when busy drops.
  always @(negedge clk) begin
    if (do_req) mon_do = mon_do + 1;
    if (done) begin
      mon_done   = mon_done + 1;
      total_done = total_done + 1;
    end
    if (prev_busy && !busy) begin
      if (sb_q.size() == 0) begin
        vectors     = vectors + 1;
        miscompares = miscompares + 1;
        $display("[TB] FAIL unexpected_txn: got an extra transaction, expected none");
      end else begin
        e = sb_q.pop_front();
        checkOutput("do_cycles", mon_do, e.do_c);
        checkOutput("done_pulses", mon_done, e.done_c);
        checkOutput("err", int'(err), e.err_v);
        checkOutput("txn_cnt", int'(txn_cnt), e.txn);
      end
      mon_do   = 0;
      mon_done = 0;
    end
    prev_busy = busy;
  end

  task automatic applyStimulus(input logic [7:0] hl, input int fl, input int gl,
                               input int gs, input int rst_at, input int pulse_at,
                               input int exp_do, input int exp_done,
                               input int exp_err, input int exp_txn);
    exp_t x;
    bit   ok;
    x.do_c   = exp_do;
    x.done_c = exp_done;
    x.err_v  = exp_err;
    x.txn    = exp_txn;
    sb_q.push_back(x);
    f_lat   = fl;
    g_lat   = gl;
    g_stuck = gs;
    ok      = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    hold_len = hl;
    @(negedge clk);
    for (int k = 1; k <= 600; k++) begin
      start = (k == pulse_at);
      rst   = (k == rst_at);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b0;
    vectors = vectors + 1;
    if (!ok) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL busy_timeout: busy still %0d after 600 cycles, expected 0", busy);
    end
  endtask

  initial begin
    int done_base;
    rst      = 1'b1;
    start    = 1'b1;
    hold_len = 8'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_do", int'(do_req), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_txn_cnt", int'(txn_cnt), 0);
    rst   = 1'b0;
    start = 1'b0;

    $display("[TB] basic handshake");
    applyStimulus(8'd3, 2, 1, 0, 0, 0, 5, 1, 0, 1);
    $display("[TB] f and g on the timeout cycle");
    applyStimulus(8'd1, 16, 16, 0, 0, 0, 17, 1, 0, 2);
    $display("[TB] hold_len zero with start during busy");
    applyStimulus(8'd0, 1, 2, 0, 0, 2, 2, 1, 0, 3);
    $display("[TB] maximum hold_len");
    applyStimulus(8'd255, 1, 1, 0, 0, 0, 256, 1, 0, 4);
    $display("[TB] f never arrives");
    applyStimulus(8'd4, 1000, 1, 0, 0, 0, 16, 0, 1, 4);
    $display("[TB] g stuck high");
    applyStimulus(8'd2, 1, 1, 1, 0, 0, 3, 0, 1, 4);
    $display("[TB] good transaction after errors");
    applyStimulus(8'd1, 1, 1, 0, 0, 0, 2, 1, 1, 5);
    $display("[TB] reset during HOLD");
    applyStimulus(8'd10, 1, 1, 0, 3, 0, 3, 0, 0, 0);

    $display("[TB] 256 back-to-back transactions");
    done_base = total_done;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(8'd1, 1, 1, 0, 0, 0, 2, 1, 0, (i + 1) % 256);
    end
    repeat (3) @(negedge clk);
    checkOutput("wrap_done_pulses", total_done - done_base, 256);
    checkOutput("scoreboard_left", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/onstate_ontransit_driver.md
ONSTATE_ONTRANSIT_DRIVER -- requirements
Module: onstate_ontransit_driver

Interface
REQ-001 SHALL have parameter HOLD_W, default 8, width of hold_len.
REQ-002 SHALL have parameter TMO, default 16, handshake timeout in clk cycles (legal range 2..255).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request one transaction; sampled in IDLE only.
REQ-006 SHALL have port hold_len, input, HOLD_W, cycles do stays high after f seen; captured with start.
REQ-007 SHALL have port do, output, 1, request line to the onstate/ontransit FSM.
REQ-008 SHALL have port f, input, 1, transit acknowledge from FSM.
REQ-009 SHALL have port g, input, 1, on-state indication from FSM.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse on successful completion.
REQ-012 SHALL have port err, output, 1, sticky timeout flag.
REQ-013 SHALL have port txn_cnt, output, 8, count of completed transactions.

Function
REQ-014 SHALL implement states IDLE, REQ, HOLD, REL, DONE; all outputs registered.
REQ-015 IDLE: do=0; start=1 -> REQ next cycle, capture hold_len (value 0 treated as 1), clear timer.
REQ-016 REQ: do=1; f=1 -> HOLD; TMO cycles in REQ without f -> IDLE with err set.
REQ-017 HOLD: do=1 for exactly captured hold_len cycles, then -> REL; f/g ignored.
REQ-018 REL: do=0; g=0 -> DONE; TMO cycles in REL with g=1 -> IDLE with err set.
REQ-019 DONE: done=1 for one cycle, txn_cnt increments, -> IDLE unconditionally.
REQ-020 do SHALL rise the cycle after REQ entry; first do edge is 1 cycle after start sampled.
REQ-021 start SHALL be ignored while busy=1; no queuing.
REQ-022 f and g arriving the same cycle as REQ entry SHALL be evaluated from the following cycle.
REQ-023 Timeout and f=1 in the same cycle SHALL resolve in favour of f (no err).
REQ-024 Timeout and g=0 in the same cycle in REL SHALL resolve in favour of g (no err).
REQ-025 txn_cnt SHALL wrap 255 -> 0 without flag.
REQ-026 err SHALL stay set until rst; subsequent transactions still run normally.
REQ-027 Timeout counter SHALL be ceil(log2(TMO+1)) bits and saturate, never wrap.

Reset
REQ-028 rst=1 SHALL force state IDLE, do=0, busy=0, done=0, err=0, txn_cnt=0, timer=0 at next clk edge.
REQ-029 rst asserted mid-transaction SHALL abort it with no done pulse and no txn_cnt change.
REQ-030 Reset value SHALL hold for the whole time rst=1; start ignored while rst=1.

Structure
REQ-031 Shared package oso_pkg SHALL hold the state encoding (IDLE..DONE), default TMO and HOLD_W.
REQ-032 Timeout counter SHALL be a sub-module oso_timer (clear, enable, expired output).
REQ-033 Hold counter SHALL be local to the top module; no other sub-modules.

Verification
REQ-034 rst high 2 cycles, start=1 hold_len=3, FSM returns f=1 after 2 cycles, g=0 after release -> do high exactly 2+3 cycles, done pulse once, txn_cnt=1.
REQ-035 start with f held 0 -> do high exactly 16 cycles, then do=0, err=1, no done, txn_cnt unchanged.
REQ-036 g held 1 after release -> err=1 after 16 REL cycles; next good transaction -> done=1, txn_cnt increments, err stays 1.
REQ-037 hold_len=0 -> HOLD lasts 1 cycle; start pulsed during busy -> no second transaction.
REQ-038 rst pulsed during HOLD -> do=0, busy=0, txn_cnt=0 next cycle, no done.
REQ-039 256 back-to-back good transactions -> txn_cnt wraps to 0, done pulses counted = 256.
